interrupt_acknowledge_control: RTL and testbench
================================================

Name: interrupt_acknowledge_control

Overview:
- Consumes the one-hot `interrupt` output of the priority resolver and runs the 8086-mode two-pulse INTA sequence.
- Drives INT, sets and clears the In-Service Register (ISR), issues IRR clear pulses and places the vector on the data bus.
- Executes OCW2 EOI/rotation commands and owns `priority_rotate`, which it feeds back to the resolver.
- Sits between the resolver, the IRR block and the data-bus buffer in the PIC core.

Parameters:
- none (8-input controller, 8086 mode only)

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- interrupt  in  8  one-hot resolved request from priority resolver (0 = none)
- inta_n  in  1  interrupt acknowledge, active low, already synchronous to clk
- ocw2_write  in  1  one-cycle strobe; ocw2_data valid
- ocw2_data  in  8  [7]=R, [6]=SL, [5]=EOI, [2:0]=L
- auto_eoi  in  1  ICW4 AEOI bit
- vector_base  in  5  ICW2 T7..T3
- int_out  out  1  INT pin to CPU
- in_service_register  out  8  ISR
- priority_rotate  out  3  level currently lowest priority (3'b111 = IR0 highest)
- clear_request  out  8  one-cycle pulse clearing IRR bit
- data_out  out  8  vector byte
- data_out_en  out  1  data bus drive enable

Behaviour:
- Reset (rst_n=0 at a clk edge), including mid-sequence:
  - state=IDLE, int_out=0, ISR=0, priority_rotate=3'b111, clear_request=0, data_out=0, data_out_en=0, rotate_in_aeoi=0.
- inta_n is registered once. A fall is detected when prev=1 and cur=0; a rise when prev=0 and cur=1. The prev register resets to 1.
- FSM states: IDLE, ACK1, GAP, ACK2.
  - IDLE: int_out <= (interrupt != 0), registered, so 1-cycle latency. On an inta fall: latch level = encode(interrupt), go to ACK1.
    - If interrupt != 0: ISR[level] <= 1, clear_request[level] pulses 1 cycle, int_out <= 0.
    - If interrupt == 0 (spurious): level = 7, no ISR set, no clear pulse.
  - ACK1: on an inta rise, go to GAP.
  - GAP: on an inta fall, go to ACK2. data_out <= {vector_base, level}, data_out_en <= 1 from the next cycle.
  - ACK2: data_out_en held 1 while inta_n is low. On an inta rise: data_out_en <= 0 and go to IDLE.
    - If auto_eoi and the sequence was not spurious: clear ISR[level].
    - If rotate_in_aeoi is also set: priority_rotate <= level.
- In ACK1/GAP/ACK2, int_out is held 0 and `interrupt` is ignored.
- An inta fall in IDLE while int_out=0 is still honoured (spurious path).
- OCW2 decode on ocw2_write, by {R,SL,EOI}:
  - 001: non-specific EOI.
  - 011: specific EOI, clear ISR[L].
  - 101: rotate on non-specific EOI.
  - 111: rotate on specific EOI, clear ISR[L], priority_rotate <= L.
  - 110: set priority, priority_rotate <= L.
  - 100: rotate_in_aeoi <= 1.
  - 000: rotate_in_aeoi <= 0.
  - 010: no-op.
- Non-specific EOI:
  - Clears the highest-priority set ISR bit, searching levels priority_rotate+1, +2, … mod 8.
  - For 101, priority_rotate <= the cleared level.
  - If ISR == 0: no change, including no rotation.
- Same-cycle collisions:
  - The EOI target is chosen from ISR before this cycle's INTA set.
  - Clears apply first, then the INTA set; set wins on the same bit.
  - If an AEOI rotate and an OCW2 rotate coincide, OCW2 wins.
- Only one ISR bit is set per sequence; multiple bits accumulate only through nesting.

Test Plan:
- Reset, then interrupt=8'h04 → int_out=1 one cycle later. inta fall → ISR=8'h04, clear_request=8'h04 for 1 cycle, int_out=0. Second inta low with vector_base=5'h08 → data_out=8'h42, data_out_en=1. Final rise → data_out_en=0, state IDLE.
- Spurious: interrupt=0, full INTA sequence → ISR unchanged, clear_request=0, data_out={vector_base,3'b111}.
- Rotation search: ISR=8'h24, priority_rotate=3'b111, ocw2 8'h20 → ISR=8'h20. Then priority_rotate=3'd4 with ISR=8'h24 and OCW2 8'hA0 → ISR=8'h04, priority_rotate=5.
- AEOI + rotate: auto_eoi=1, ocw2 8'h80, interrupt=8'h10 INTA sequence → ISR=0 after the final rise, priority_rotate=4. Then ocw2 8'hC1 → priority_rotate=1.
- Collision: during the first-INTA set of ISR[2] with ISR=8'h04 beforehand, ocw2 8'h62 in the same cycle → ISR=8'h04 (set wins). Non-specific EOI with ISR=0 → no change.
- rst_n=0 while in GAP → next cycle all outputs at reset values. A following inta rise alone causes no state change.

Source files
------------

// File: rtl/interrupt_acknowledge_control.sv
// 8086-mode INTA sequencer for an 8-input PIC core: drives INT, owns the ISR,
// pulses IRR clears, places the vector byte on the bus and executes OCW2 EOI/rotation.
module interrupt_acknowledge_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  input  logic       auto_eoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [2:0] priority_rotate,
  output logic [7:0] clear_request,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  typedef enum logic [1:0] {StIdle, StAck1, StGap, StAck2} state_e;

  state_e     state_q;
  logic       inta_cur_q, inta_prev_q;
  logic [2:0] level_q;
  logic       spurious_q;
  logic       rotate_in_aeoi_q;

  logic       inta_fall, inta_rise;
  logic [2:0] irq_level;
  logic       ns_found;
  logic [2:0] ns_level;
  logic [2:0] idx;
  logic [7:0] clear_mask, set_mask, isr_next;
  logic       rot_ocw_en;
  logic [2:0] rot_ocw_val;
  logic       raeoi_d;
  logic       aeoi_fire, aeoi_rot_en;
  logic       unused_ocw2_bits;

  // D4/D3 only distinguish OCW2 from OCW3 upstream; the strobe already did that.
  assign unused_ocw2_bits = ^ocw2_data[4:3];

  assign inta_fall = inta_prev_q & ~inta_cur_q;
  assign inta_rise = ~inta_prev_q & inta_cur_q;

  // An empty request encodes to 7, which is exactly the spurious vector level.
  always_comb begin
    irq_level = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (interrupt[i]) irq_level = 3'(i);
    end
  end

  // Highest-priority in-service level: search upward from the lowest-priority level.
  always_comb begin
    ns_found = 1'b0;
    ns_level = '0;
    idx      = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = priority_rotate + 3'(i);
      if (!ns_found && in_service_register[idx]) begin
        ns_found = 1'b1;
        ns_level = idx;
      end
    end
  end

  always_comb begin
    clear_mask  = '0;
    rot_ocw_en  = 1'b0;
    rot_ocw_val = ocw2_data[2:0];
    raeoi_d     = rotate_in_aeoi_q;
    if (ocw2_write) begin
      case (ocw2_data[7:5])
        3'b001: if (ns_found) clear_mask[ns_level] = 1'b1;
        3'b011: clear_mask[ocw2_data[2:0]] = 1'b1;
        3'b101: begin
          if (ns_found) begin
            clear_mask[ns_level] = 1'b1;
            rot_ocw_en           = 1'b1;
            rot_ocw_val          = ns_level;
          end
        end
        3'b111: begin
          clear_mask[ocw2_data[2:0]] = 1'b1;
          rot_ocw_en                 = 1'b1;
        end
        3'b110:  rot_ocw_en = 1'b1;
        3'b100:  raeoi_d = 1'b1;
        3'b000:  raeoi_d = 1'b0;
        default: ;
      endcase
    end
    aeoi_fire   = (state_q == StAck2) && inta_rise && auto_eoi && !spurious_q;
    aeoi_rot_en = aeoi_fire && rotate_in_aeoi_q;
    if (aeoi_fire) clear_mask[level_q] = 1'b1;
    set_mask = '0;
    if ((state_q == StIdle) && inta_fall && (|interrupt)) set_mask[irq_level] = 1'b1;
    // Clears first, then the acknowledge set, so a set wins on the same bit.
    isr_next = (in_service_register & ~clear_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= StIdle;
      inta_cur_q          <= 1'b1;
      inta_prev_q         <= 1'b1;
      level_q             <= '0;
      spurious_q          <= 1'b0;
      rotate_in_aeoi_q    <= 1'b0;
      int_out             <= 1'b0;
      in_service_register <= '0;
      priority_rotate     <= 3'b111;
      clear_request       <= '0;
      data_out            <= '0;
      data_out_en         <= 1'b0;
    end else begin
      inta_cur_q          <= inta_n;
      inta_prev_q         <= inta_cur_q;
      clear_request       <= set_mask;
      in_service_register <= isr_next;
      rotate_in_aeoi_q    <= raeoi_d;
      if (rot_ocw_en) begin
        priority_rotate <= rot_ocw_val;
      end else if (aeoi_rot_en) begin
        priority_rotate <= level_q;
      end
      unique case (state_q)
        StIdle: begin
          int_out <= |interrupt;
          if (inta_fall) begin
            level_q    <= irq_level;
            spurious_q <= ~|interrupt;
            int_out    <= 1'b0;
            state_q    <= StAck1;
          end
        end
        StAck1: begin
          int_out <= 1'b0;
          if (inta_rise) state_q <= StGap;
        end
        StGap: begin
          int_out <= 1'b0;
          if (inta_fall) begin
            data_out    <= {vector_base, level_q};
            data_out_en <= 1'b1;
            state_q     <= StAck2;
          end
        end
        StAck2: begin
          int_out <= 1'b0;
          if (inta_rise) begin
            data_out_en <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_acknowledge_control.sv
// Randomized bench for interrupt_acknowledge_control against a transaction-level model
// of the ISR, rotation pointer and rotate-in-AEOI flag.
module tb_interrupt_acknowledge_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] interrupt;
  logic       inta_n;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic       auto_eoi;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic [7:0] clear_request;
  logic [7:0] data_out;
  logic       data_out_en;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] m_isr;
  int         m_rot;
  bit         m_raeoi;

  always #5 clk = ~clk;

  interrupt_acknowledge_control dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .interrupt          (interrupt),
    .inta_n             (inta_n),
    .ocw2_write         (ocw2_write),
    .ocw2_data          (ocw2_data),
    .auto_eoi           (auto_eoi),
    .vector_base        (vector_base),
    .int_out            (int_out),
    .in_service_register(in_service_register),
    .priority_rotate    (priority_rotate),
    .clear_request      (clear_request),
    .data_out           (data_out),
    .data_out_en        (data_out_en)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".isr"}, 32'(in_service_register), 32'(m_isr));
    check_eq({tag, ".rot"}, 32'(priority_rotate), 32'(m_rot));
  endtask

  // EOI / rotation rules applied to the model ISR and pointer.
  task automatic model_ocw(input logic [7:0] d);
    int l   = int'(d[2:0]);
    int hit = -1;
    for (int i = 1; i <= 8; i++) begin
      if (hit < 0 && m_isr[(m_rot + i) % 8]) hit = (m_rot + i) % 8;
    end
    case (d[7:5])
      3'b001: if (hit >= 0) m_isr[hit] = 1'b0;
      3'b011: m_isr[l] = 1'b0;
      3'b101: if (hit >= 0) begin
        m_isr[hit] = 1'b0;
        m_rot      = hit;
      end
      3'b111: begin
        m_isr[l] = 1'b0;
        m_rot    = l;
      end
      3'b110:  m_rot = l;
      3'b100:  m_raeoi = 1'b1;
      3'b000:  m_raeoi = 1'b0;
      default: ;
    endcase
  endtask

  task automatic ocw2_cmd(input logic [7:0] d);
    ocw2_write = 1'b1;
    ocw2_data  = d;
    tick(1);
    ocw2_write = 1'b0;
    model_ocw(d);
    check_state($sformatf("ocw%02h", d));
  endtask

  // Full two-pulse acknowledge; optionally an OCW2 lands on the ISR-set cycle.
  task automatic inta_seq(input logic [7:0] irq, input bit with_ocw, input logic [7:0] od);
    bit spur = (irq == 8'h00);
    int lvl  = 7;
    for (int i = 0; i < 8; i++) if (irq[i]) lvl = i;
    interrupt = irq;
    tick(1);
    check_eq("int_assert", 32'(int_out), 32'(!spur));
    inta_n = 1'b0;
    tick(1);
    if (with_ocw) begin
      ocw2_write = 1'b1;
      ocw2_data  = od;
    end
    tick(1);
    ocw2_write = 1'b0;
    if (with_ocw) model_ocw(od);
    if (!spur) m_isr[lvl] = 1'b1;
    check_eq("clr_pulse", 32'(clear_request), 32'(irq));
    check_eq("int_drop", 32'(int_out), 32'd0);
    check_state("ack1");
    interrupt = 8'h00;
    tick(1);
    check_eq("clr_end", 32'(clear_request), 32'd0);
    inta_n = 1'b1;
    tick(2);
    check_eq("gap_en", 32'(data_out_en), 32'd0);
    inta_n = 1'b0;
    tick(2);
    check_eq("ack2_en", 32'(data_out_en), 32'd1);
    check_eq("vector", 32'(data_out), 32'({vector_base, 3'(lvl)}));
    tick(1);
    check_eq("ack2_hold", 32'(data_out_en), 32'd1);
    inta_n = 1'b1;
    tick(2);
    if (auto_eoi && !spur) begin
      m_isr[lvl] = 1'b0;
      if (m_raeoi) m_rot = lvl;
    end
    check_eq("end_en", 32'(data_out_en), 32'd0);
    check_state("end");
  endtask

  initial begin
    rst_n       = 1'b0;
    interrupt   = 8'h00;
    inta_n      = 1'b1;
    ocw2_write  = 1'b0;
    ocw2_data   = 8'h00;
    auto_eoi    = 1'b0;
    vector_base = 5'h08;
    m_isr       = 8'h00;
    m_rot       = 7;
    m_raeoi     = 1'b0;
    tick(2);
    check_eq("rst_int", 32'(int_out), 32'd0);
    check_eq("rst_clr", 32'(clear_request), 32'd0);
    check_eq("rst_dout", 32'(data_out), 32'd0);
    check_eq("rst_en", 32'(data_out_en), 32'd0);
    check_state("rst");
    rst_n = 1'b1;
    tick(1);

    inta_seq(8'h04, 1'b0, 8'h00);
    check_eq("basic_vec", 32'(data_out), 32'h42);
    ocw2_cmd(8'h20);
    inta_seq(8'h00, 1'b0, 8'h00);

    inta_seq(8'h04, 1'b0, 8'h00);
    inta_seq(8'h20, 1'b0, 8'h00);
    ocw2_cmd(8'h20);
    check_eq("ns_eoi_isr", 32'(in_service_register), 32'h20);
    ocw2_cmd(8'hC4);
    inta_seq(8'h04, 1'b0, 8'h00);
    ocw2_cmd(8'hA0);
    check_eq("rot_eoi_isr", 32'(in_service_register), 32'h04);
    check_eq("rot_eoi_rot", 32'(priority_rotate), 32'd5);
    ocw2_cmd(8'h62);

    auto_eoi = 1'b1;
    ocw2_cmd(8'h80);
    inta_seq(8'h10, 1'b0, 8'h00);
    check_eq("aeoi_isr", 32'(in_service_register), 32'h00);
    check_eq("aeoi_rot", 32'(priority_rotate), 32'd4);
    ocw2_cmd(8'hC1);

    auto_eoi = 1'b0;
    inta_seq(8'h04, 1'b0, 8'h00);
    inta_seq(8'h04, 1'b1, 8'h62);
    check_eq("collide_isr", 32'(in_service_register), 32'h04);
    ocw2_cmd(8'h62);
    ocw2_cmd(8'h20);

    // Reset while parked between the two acknowledge pulses.
    interrupt = 8'h08;
    tick(1);
    inta_n = 1'b0;
    tick(2);
    interrupt = 8'h00;
    inta_n    = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    m_isr   = 8'h00;
    m_rot   = 7;
    m_raeoi = 1'b0;
    check_eq("grst_int", 32'(int_out), 32'd0);
    check_eq("grst_clr", 32'(clear_request), 32'd0);
    check_eq("grst_dout", 32'(data_out), 32'd0);
    check_eq("grst_en", 32'(data_out_en), 32'd0);
    check_state("grst");
    rst_n = 1'b1;
    tick(3);
    check_eq("post_en", 32'(data_out_en), 32'd0);
    check_eq("post_int", 32'(int_out), 32'd0);
    inta_seq(8'h02, 1'b0, 8'h00);

    for (int it = 0; it < 60; it++) begin
      int op = int'($urandom_range(0, 4));
      auto_eoi    = 1'($urandom_range(0, 1));
      vector_base = 5'($urandom);
      if (op < 2) begin
        logic [7:0] d = 8'($urandom) & 8'hE7;
        ocw2_cmd(d);
      end else begin
        logic [7:0] irq = ($urandom_range(0, 7) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
        bit         wo  = ($urandom_range(0, 3) == 0);
        logic [7:0] od  = 8'($urandom) & 8'hE7;
        inta_seq(irq, wo, od);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
